serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
Bit-serial adder sequencer that drives a single external full-adder slice, one bit per clock, LSB first. It captures two WIDTH-bit operands and a carry-in, presents one bit pair per cycle to the slice, and keeps the slice's carry-out in a flop as the next cycle's carry-in. It shifts the slice's sum bit into a result register. It provides a start/busy/done handshake to the surrounding datapath, so one slice can stand in for a full WIDTH-bit ripple chain.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  request; sampled only in IDLE.
a_in  in  WIDTH  operand A; captured on the accepting edge.
b_in  in  WIDTH  operand B; captured on the accepting edge.
cin  in  1  carry-in; captured on the accepting edge.
busy  out  1  high while state is RUN or DONE.
done  out  1  one-cycle completion pulse.
sum  out  WIDTH  registered result; holds its value between completions.
cout  out  1  registered final carry.
slice_a  out  1  A bit to the slice.
slice_b  out  1  B bit to the slice.
slice_cin  out  1  carry bit to the slice.
slice_s  in  1  sum bit from the slice.
slice_cout  in  1  carry-out from the slice.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high: state=IDLE; all shift registers, the carry flop and the bit counter are 0; busy=0, done=0, sum=0, cout=0.
- FSM states:
  - IDLE: busy=0. If start=1 at an edge, load a_sh<=a_in, b_sh<=b_in, carry<=cin, cnt<=0, and go to RUN. Otherwise stay in IDLE.
  - RUN: on each edge, sum_sh<={slice_s, sum_sh[WIDTH-1:1]}, a_sh>>=1, b_sh>>=1, carry<=slice_cout, cnt<=cnt+1. When cnt==WIDTH-1 at the edge:
    - sum<={slice_s, sum_sh[WIDTH-1:1]}
    - cout<=slice_cout
    - go to DONE.
  - DONE: done=1 for exactly this one cycle. The next edge always goes to IDLE.
- Slice drive (combinational from registers):
  - In RUN: slice_a=a_sh[0], slice_b=b_sh[0], slice_cin=carry.
  - In IDLE and DONE: all three slice outputs are 0.
- Latency: for start sampled on edge E0, bits are processed on edges E1..EWIDTH. done is high in the cycle after EWIDTH. Next acceptance is possible at EWIDTH+2, giving one operation per WIDTH+2 cycles.
- Result: {cout,sum} = a_in + b_in + cin, exact; no overflow is possible in WIDTH+1 bits.
- sum and cout change only at the last RUN edge and on reset. They stay stable through DONE and IDLE until the next completion.
- start while busy=1 is ignored. Operand changes after the accepting edge have no effect.
- start held high continuously: accepted at every IDLE cycle, giving back-to-back operations with one IDLE cycle between them.
- Reset mid-operation: immediate return to IDLE with outputs cleared. No done pulse for the aborted operation.
- Counter width is ceil(log2(WIDTH)) bits and never wraps past WIDTH-1.
- Slice timing: the slice path is combinational, 3 gate delays a->cout. The clock period must exceed the slice's a/b/cin->s/cout delay plus flop setup. The bench clock period is >= 10 time units.

Test Plan:
1. WIDTH=8, a=0x00, b=0x00, cin=0 -> done exactly 8 edges after the accepting edge; sum=0x00, cout=0; busy high for 9 cycles.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. slice_cin=0 in the first RUN cycle and 1 in every later RUN cycle.
3. a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0; previous sum held until that op's last edge.
4. start held high, operand pairs (0x12,0x34,0) then (0xF0,0x0F,1) -> sums 0x46/cout 0 then 0x00/cout 1. done pulses are 10 cycles apart; operand changes during busy are ignored.
5. rst pulsed during the 4th RUN cycle of a=0xFF, b=0xFF -> busy=0, sum=0, cout=0 immediately, no done pulse. A following op 0x03+0x04+0 gives sum=0x07, cout=0.
6. Idle check: in IDLE and DONE, slice_a, slice_b and slice_cin are 0. done is never high for two consecutive cycles across 50 random operations; each result is checked against a+b+cin.

Source files
------------

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencer driving one external full-adder slice, LSB first.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; one operation per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, not queued.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  input  logic             slice_s,
  input  logic             slice_cout
);

  // Bit counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operand shifters: bit 0 is always the bit currently presented to the slice.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Partial-sum shifter. Only the upper WIDTH-1 bits of a full WIDTH-bit
  // right-shifter ever survive to the final result (the bit falling out of
  // position 0 is discarded), so just those bits are kept.
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Per-cycle control decoded from the FSM.
  logic load;
  logic step;
  logic last;

  // New sum bit enters at the MSB; after WIDTH steps the LSB of the operands
  // has travelled down to bit 0.
  assign sum_nxt = {slice_s, sum_sh};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, handshake outputs and slice drive.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        step      = 1'b1;
        slice_a   = a_sh[0];
        slice_b   = b_sh[0];
        slice_cin = carry;
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Single-cycle completion; start is not looked at here, which is what
        // forces the one IDLE cycle between back-to-back operations.
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, per-bit shifting, carry feedback and bit counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sh  <= a_in;
      b_sh  <= b_in;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_nxt[WIDTH-1:1];
      carry  <= slice_cout;
      // Park at zero on the final bit so the counter never runs past WIDTH-1.
      cnt    <= last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Result register: updated only on the final bit, so the previous result
  // stays visible for the whole of the next operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last) begin
      sum  <= sum_nxt;
      cout <= slice_cout;
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed and random operations through serial_add_seq with a full-adder slice model.
// Expected {cout,sum} values are queued at issue time; a negedge monitor pops them on each done pulse.
// Inputs are driven on negedges; the monitor also watches done spacing and idle slice outputs.
module tb_serial_add_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic             slice_s;
  logic             slice_cout;

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .cin        (cin),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .cout       (cout),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_s    (slice_s),
    .slice_cout (slice_cout)
  );

  // External full-adder slice.
  assign slice_s    = slice_a ^ slice_b ^ slice_cin;
  assign slice_cout = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [8:0] sb_q[$];
  int         cyc = 0;
  int         done_count = 0;
  int         last_done_cyc = 0;
  int         prev_done_cyc = 0;
  logic       prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: scoreboard pop on done, done spacing, idle slice drive.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        done_count++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        check("done_single_cycle", 32'(prev_done), 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("result", 32'({cout, sum}), 32'(sb_q.pop_front()));
        end
      end
      if (!busy || done) begin
        check("slice_idle_zero", 32'({slice_a, slice_b, slice_cin}), 32'd0);
      end
      prev_done = done;
    end
  end

  // One full operation from an IDLE negedge back to an IDLE negedge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp, output logic [7:0] cin_trace);
    logic [8:0] old_res;
    int         lat;
    int         busy_n;
    bit         held_bad;
    old_res = {cout, sum};
    check("idle_before_op", 32'(busy), 32'd0);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    cin   = c;
    sb_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in  = ~a;
    b_in  = a ^ 8'h3C;
    cin   = ~c;
    lat       = -1;
    busy_n    = 0;
    held_bad  = 1'b0;
    cin_trace = '0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      busy_n++;
      if (done) begin
        if (lat < 0) lat = i;
      end else begin
        if (i < WIDTH) cin_trace[i] = slice_cin;
        if ({cout, sum} !== old_res) held_bad = 1'b1;
      end
      @(negedge clk);
    end
    check("done_latency", 32'(lat), 32'd8);
    check("busy_cycles", 32'(busy_n), 32'd9);
    check("result_held_during_op", 32'(held_bad), 32'd0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] exp;
  } vec_t;

  initial begin
    logic [7:0] trace;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    int         base;
    vec_t       extra[3];

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'({cout, sum}), 32'd0);
    check("reset_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: all zeros.
    run_op(8'h00, 8'h00, 1'b0, 9'h000, trace);
    check("t1_cin_trace", 32'(trace), 32'h00);

    // 2: carry ripples through every bit after the first.
    run_op(8'hFF, 8'h01, 1'b0, 9'h100, trace);
    check("t2_cin_trace", 32'(trace), 32'hFE);

    // 3: carry-in propagates the whole width, then a result change.
    run_op(8'hA5, 8'h5A, 1'b1, 9'h100, trace);
    check("t3a_cin_trace", 32'(trace), 32'hFF);
    run_op(8'h7F, 8'h01, 1'b0, 9'h080, trace);
    check("t3b_cin_trace", 32'(trace), 32'hFE);

    // 5: reset during the 4th RUN cycle of 0xFF+0xFF (sum currently 0x80).
    check("t5_idle", 32'(busy), 32'd0);
    start = 1'b1;
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    base = done_count;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_result", 32'({cout, sum}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_no_done_after_abort", 32'(done_count - base), 32'd0);
    run_op(8'h03, 8'h04, 1'b0, 9'h007, trace);

    // 4: start held high, operands changed while busy.
    check("t4_idle", 32'(busy), 32'd0);
    base  = done_count;
    start = 1'b1;
    a_in  = 8'h12;
    b_in  = 8'h34;
    cin   = 1'b0;
    sb_q.push_back(9'h046);
    @(posedge clk);
    @(negedge clk);
    a_in = 8'hF0;
    b_in = 8'h0F;
    cin  = 1'b1;
    sb_q.push_back(9'h100);
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in  = 8'h55;
    b_in  = 8'hAA;
    cin   = 1'b1;
    for (int i = 0; i < 40 && done_count < base + 2; i++) @(negedge clk);
    check("t4_done_count", 32'(done_count - base), 32'd2);
    check("t4_done_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd10);
    repeat (14) @(negedge clk);
    check("t4_no_third_op", 32'(done_count - base), 32'd2);
    check("t4_idle_after", 32'(busy), 32'd0);

    // A few more directed corner sums.
    extra[0] = '{a: 8'h80, b: 8'h80, c: 1'b1, exp: 9'h101};
    extra[1] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, exp: 9'h1FF};
    extra[2] = '{a: 8'h55, b: 8'hAA, c: 1'b0, exp: 9'h0FF};
    for (int i = 0; i < 3; i++) begin
      run_op(extra[i].a, extra[i].b, extra[i].c, extra[i].exp, trace);
    end

    // 6: random operations.
    for (int i = 0; i < 50; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, trace);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
